// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle logic/arith/shift ops plus iterative signed MUL/DIV.
// Optional divider enabled by defining ALU_DIV_EN.
module seq_alu #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clock,
  input  logic                 clear,
  input  logic                 start,
  input  logic [4:0]           ALU_op,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic [2*WIDTH-1:0]   C,
  output logic                 busy,
  output logic                 done,
  output logic                 div_by_zero,
  output logic                 illegal_op
);

  localparam int unsigned W2 = 2 * WIDTH;
  localparam int unsigned LW = $clog2(WIDTH);
  localparam int unsigned CW = LW + 1;

  localparam logic [4:0] OP_ADD  = 5'b00001;
  localparam logic [4:0] OP_SUB  = 5'b00010;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_NOT  = 5'b00111;
  localparam logic [4:0] OP_NEG  = 5'b01000;
  localparam logic [4:0] OP_MUL  = 5'b01001;
  localparam logic [4:0] OP_SHR  = 5'b01010;
  localparam logic [4:0] OP_SHRA = 5'b01011;
  localparam logic [4:0] OP_SHL  = 5'b01100;
  localparam logic [4:0] OP_ROR  = 5'b01101;
  localparam logic [4:0] OP_ROL  = 5'b01110;
`ifdef ALU_DIV_EN
  localparam logic [4:0] OP_DIV  = 5'b00011;
`endif

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [W2-1:0]     acc_q, acc_d;
  logic [WIDTH-1:0]  opnd_q, opnd_d;
  logic              neg_lo_q, neg_lo_d;
  logic [W2-1:0]     c_q, c_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              dbz_q, dbz_d;
  logic              ill_q, ill_d;
`ifdef ALU_DIV_EN
  logic              neg_hi_q, neg_hi_d;
  logic              is_div_q, is_div_d;
`endif

  logic [WIDTH-1:0]  abs_a_c, abs_b_c, lo_c;
  logic [LW-1:0]     amt_c;
  logic [W2-1:0]     rot_r_c, rot_l_c;
  logic [WIDTH:0]    mul_sum_c;
  logic [W2-1:0]     mul_step_c, mul_fix_c;
`ifdef ALU_DIV_EN
  logic [WIDTH-1:0]  rsh_c, quo_fix_c, rem_fix_c;
  logic [WIDTH:0]    trial_c;
  logic [W2-1:0]     div_step_c;
`endif

  assign C           = c_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign illegal_op  = ill_q;

  // Operand magnitudes; the most negative value maps to 2^(WIDTH-1) as unsigned.
  assign abs_a_c = A[WIDTH-1] ? (~A + WIDTH'(1)) : A;
  assign abs_b_c = B[WIDTH-1] ? (~B + WIDTH'(1)) : B;

  assign amt_c   = A[LW-1:0];
  assign rot_r_c = {B, B} >> amt_c;
  assign rot_l_c = {B, B} << amt_c;

  // Shift-add step: acc holds {partial product, remaining multiplier bits}.
  assign mul_sum_c  = {1'b0, acc_q[W2-1:WIDTH]}
                    + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
  assign mul_step_c = {mul_sum_c, acc_q[WIDTH-1:1]};
  assign mul_fix_c  = neg_lo_q ? (~acc_q + W2'(1)) : acc_q;

`ifdef ALU_DIV_EN
  // Restoring step: acc holds {remainder, dividend/quotient shift register}.
  assign rsh_c      = {acc_q[W2-2:WIDTH], acc_q[WIDTH-1]};
  assign trial_c    = {1'b0, rsh_c} - {1'b0, opnd_q};
  assign div_step_c = trial_c[WIDTH] ? {rsh_c, acc_q[WIDTH-2:0], 1'b0}
                                     : {trial_c[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
  assign quo_fix_c  = neg_lo_q ? (~acc_q[WIDTH-1:0] + WIDTH'(1)) : acc_q[WIDTH-1:0];
  assign rem_fix_c  = neg_hi_q ? (~acc_q[W2-1:WIDTH] + WIDTH'(1)) : acc_q[W2-1:WIDTH];
`endif

  // Single-cycle result (LO half).
  always_comb begin
    lo_c = '0;
    case (ALU_op)
      OP_ADD:  lo_c = A + B;
      OP_SUB:  lo_c = A - B;
      OP_AND:  lo_c = A & B;
      OP_OR:   lo_c = A | B;
      OP_NOT:  lo_c = ~A;
      OP_NEG:  lo_c = WIDTH'(0) - A;
      OP_SHR:  lo_c = B >> amt_c;
      OP_SHRA: lo_c = $unsigned($signed(B) >>> amt_c);
      OP_SHL:  lo_c = B << amt_c;
      OP_ROR:  lo_c = rot_r_c[WIDTH-1:0];
      OP_ROL:  lo_c = rot_l_c[W2-1:WIDTH];
      default: lo_c = '0;
    endcase
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      neg_lo_q <= 1'b0;
      c_q      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
      ill_q    <= 1'b0;
`ifdef ALU_DIV_EN
      neg_hi_q <= 1'b0;
      is_div_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      neg_lo_q <= neg_lo_d;
      c_q      <= c_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      dbz_q    <= dbz_d;
      ill_q    <= ill_d;
`ifdef ALU_DIV_EN
      neg_hi_q <= neg_hi_d;
      is_div_q <= is_div_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    neg_lo_d = neg_lo_q;
    c_d      = c_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    dbz_d    = dbz_q;
    ill_d    = ill_q;
`ifdef ALU_DIV_EN
    neg_hi_d = neg_hi_q;
    is_div_d = is_div_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          dbz_d = 1'b0;
          ill_d = 1'b0;
          case (ALU_op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOT, OP_NEG,
            OP_SHR, OP_SHRA, OP_SHL, OP_ROR, OP_ROL: begin
              c_d    = {{WIDTH{1'b0}}, lo_c};
              done_d = 1'b1;
            end
            OP_MUL: begin
              busy_d   = 1'b1;
              state_d  = S_RUN;
              cnt_d    = '0;
              acc_d    = {{WIDTH{1'b0}}, abs_a_c};
              opnd_d   = abs_b_c;
              neg_lo_d = A[WIDTH-1] ^ B[WIDTH-1];
`ifdef ALU_DIV_EN
              is_div_d = 1'b0;
`endif
            end
`ifdef ALU_DIV_EN
            OP_DIV: begin
              if (B == '0) begin
                c_d    = {A, {WIDTH{1'b1}}};
                dbz_d  = 1'b1;
                done_d = 1'b1;
              end else begin
                busy_d   = 1'b1;
                state_d  = S_RUN;
                cnt_d    = '0;
                acc_d    = {{WIDTH{1'b0}}, abs_a_c};
                opnd_d   = abs_b_c;
                neg_lo_d = A[WIDTH-1] ^ B[WIDTH-1];
                neg_hi_d = A[WIDTH-1];
                is_div_d = 1'b1;
              end
            end
`endif
            default: begin
              c_d    = '0;
              ill_d  = 1'b1;
              done_d = 1'b1;
            end
          endcase
        end
      end
      S_RUN: begin
        cnt_d = cnt_q + CW'(1);
`ifdef ALU_DIV_EN
        acc_d = is_div_q ? div_step_c : mul_step_c;
`else
        acc_d = mul_step_c;
`endif
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
`ifdef ALU_DIV_EN
        c_d     = is_div_q ? {rem_fix_c, quo_fix_c} : mul_fix_c;
`else
        c_d     = mul_fix_c;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: cycle-level behavioural model plus directed literal checks.
module tb_seq_alu;

  localparam int unsigned WIDTH = 32;
  localparam int LAT = WIDTH + 1;

  logic              clock, clear, start;
  logic [4:0]        op_r;
  logic [WIDTH-1:0]  a_r, b_r;
  logic [2*WIDTH-1:0] C;
  logic              busy, done, div_by_zero, illegal_op;

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;

  logic [63:0] m_c, m_pc;
  logic        m_busy, m_done, m_dbz, m_ill;
  int          m_left;

  seq_alu #(.WIDTH(WIDTH)) dut (
    .clock(clock), .clear(clear), .start(start), .ALU_op(op_r),
    .A(a_r), .B(b_r), .C(C), .busy(busy), .done(done),
    .div_by_zero(div_by_zero), .illegal_op(illegal_op)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference result of one op from the arithmetic definitions.
  function automatic void ref_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [63:0] c, output logic dbz, output logic ill,
                                 output logic multi);
    logic [31:0] lo;
    longint sa, sb, q, r;
    int amt;
    c = '0; dbz = 1'b0; ill = 1'b0; multi = 1'b0; lo = '0;
    amt = int'(a[4:0]);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      5'b00001: lo = a + b;
      5'b00010: lo = a - b;
      5'b00101: lo = a & b;
      5'b00110: lo = a | b;
      5'b00111: lo = ~a;
      5'b01000: lo = 32'd0 - a;
      5'b01001: begin multi = 1'b1; c = 64'(sa * sb); end
      5'b01010: lo = b >> amt;
      5'b01011: lo = 32'($signed(b) >>> amt);
      5'b01100: lo = b << amt;
      5'b01101: lo = (b >> amt) | (b << (32 - amt));
      5'b01110: lo = (b << amt) | (b >> (32 - amt));
`ifdef ALU_DIV_EN
      5'b00011: begin
        if (b == 32'd0) begin
          c = {a, 32'hFFFF_FFFF};
          dbz = 1'b1;
        end else begin
          multi = 1'b1;
          q = sa / sb;
          r = sa % sb;
          c = {r[31:0], q[31:0]};
        end
      end
`endif
      default: ill = 1'b1;
    endcase
    if (!multi && !ill && !dbz) c = {32'd0, lo};
  endfunction

  task automatic model_reset();
    m_c = '0; m_pc = '0; m_busy = 1'b0; m_done = 1'b0;
    m_dbz = 1'b0; m_ill = 1'b0; m_left = 0;
  endtask

  // Advance the model by one rising edge using the inputs the DUT sampled.
  task automatic model_step();
    logic busy_pre, dbz, ill, multi;
    logic [63:0] c;
    busy_pre = m_busy;
    m_done = 1'b0;
    if (clear) begin
      model_reset();
    end else begin
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_c = m_pc; m_busy = 1'b0; m_done = 1'b1;
        end
      end
      if (start && !busy_pre) begin
        ref_op(op_r, a_r, b_r, c, dbz, ill, multi);
        m_dbz = dbz; m_ill = ill;
        if (multi) begin
          m_busy = 1'b1; m_left = LAT; m_pc = c;
        end else begin
          m_c = c; m_done = 1'b1;
        end
      end
    end
  endtask

  task automatic compare();
    chk("C", C, m_c);
    chk("busy", 64'(busy), 64'(m_busy));
    chk("done", 64'(done), 64'(m_done));
    chk("div_by_zero", 64'(div_by_zero), 64'(m_dbz));
    chk("illegal_op", 64'(illegal_op), 64'(m_ill));
    if (done === 1'b1) done_cnt++;
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
    compare();
  endtask

  // Issue one op, scramble inputs afterwards, wait for done; report latency and busy cycles.
  task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int bcnt);
    start = 1'b1; op_r = op; a_r = a; b_r = b;
    tick();
    start = 1'b0; a_r = $urandom; b_r = $urandom; op_r = 5'($urandom);
    lat = 0;
    bcnt = busy ? 1 : 0;
    while (done !== 1'b1 && lat < 100) begin
      tick();
      lat++;
      if (busy === 1'b1) bcnt++;
    end
    if (done !== 1'b1) begin
      total++; bad++;
      $display("FAIL done_timeout op=%b waited=%0d", op, lat);
    end
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] corner [5];
    corner[0] = 32'h0; corner[1] = 32'h1; corner[2] = 32'hFFFF_FFFF;
    corner[3] = 32'h8000_0000; corner[4] = 32'h7FFF_FFFF;
    if ($urandom_range(0, 3) == 0) return corner[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  initial begin
    int lat, bcnt, dc0;
    logic [4:0] ops [13];
    logic [4:0] long_op;
    ops[0] = 5'b00001; ops[1] = 5'b00010; ops[2] = 5'b00011; ops[3] = 5'b00101;
    ops[4] = 5'b00110; ops[5] = 5'b00111; ops[6] = 5'b01000; ops[7] = 5'b01001;
    ops[8] = 5'b01010; ops[9] = 5'b01011; ops[10] = 5'b01100; ops[11] = 5'b01101;
    ops[12] = 5'b01110;

    model_reset();
    clear = 1'b1; start = 1'b0; op_r = '0; a_r = '0; b_r = '0;
    tick();
    tick();
    chk("reset_C", C, 64'h0);
    chk("reset_flags", {60'h0, busy, done, div_by_zero, illegal_op}, 64'h0);
    clear = 1'b0;
    tick();

    // MUL -3*7: 33-cycle latency, busy for exactly 33 cycles.
    run_op(5'b01001, 32'hFFFF_FFFD, 32'd7, lat, bcnt);
    chk("mul_lat", 64'(lat), 64'd33);
    chk("mul_busy_cycles", 64'(bcnt), 64'd33);
    chk("mul_neg3x7", C, 64'hFFFF_FFFF_FFFF_FFEB);
    run_op(5'b01001, 32'h8000_0000, 32'h8000_0000, lat, bcnt);
    chk("mul_min_min", C, 64'h4000_0000_0000_0000);

`ifdef ALU_DIV_EN
    run_op(5'b00011, 32'hFFFF_FFEF, 32'd5, lat, bcnt);
    chk("div_lat", 64'(lat), 64'd33);
    chk("div_neg17_5", C, 64'hFFFF_FFFE_FFFF_FFFD);
    run_op(5'b00011, 32'd100, 32'd0, lat, bcnt);
    chk("div0_lat", 64'(lat), 64'd0);
    chk("div0_C", C, 64'h0000_0064_FFFF_FFFF);
    chk("div0_flag", 64'(div_by_zero), 64'd1);
    run_op(5'b00011, 32'h8000_0000, 32'hFFFF_FFFF, lat, bcnt);
    chk("div_min_m1", C, 64'h0000_0000_8000_0000);
    long_op = 5'b00011;
`else
    run_op(5'b00011, 32'd10, 32'd2, lat, bcnt);
    chk("nodiv_lat", 64'(lat), 64'd0);
    chk("nodiv_C", C, 64'h0);
    chk("nodiv_ill", 64'(illegal_op), 64'd1);
    long_op = 5'b01001;
`endif

    run_op(5'b01110, 32'd1, 32'h8000_0001, lat, bcnt);
    chk("rol", C, 64'h0000_0000_0000_0003);
    run_op(5'b01011, 32'd4, 32'h8000_0000, lat, bcnt);
    chk("shra", C, 64'h0000_0000_F800_0000);
    run_op(5'b00001, 32'hFFFF_FFFF, 32'd1, lat, bcnt);
    chk("add_wrap", C, 64'h0);
    run_op(5'b11111, 32'd3, 32'd4, lat, bcnt);
    chk("op11111_ill", 64'(illegal_op), 64'd1);
    chk("op11111_C", C, 64'h0);

    // Start pulsed mid-MUL is ignored.
    dc0 = done_cnt;
    start = 1'b1; op_r = 5'b01001; a_r = 32'd6; b_r = 32'd7;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    start = 1'b1; op_r = 5'b00001; a_r = 32'd1; b_r = 32'd1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 40; i++) tick();
    chk("ignored_start_dones", 64'(done_cnt - dc0), 64'd1);
    chk("ignored_start_C", C, 64'd42);

    // Clear at iteration 10 of a long op aborts it immediately.
    dc0 = done_cnt;
    start = 1'b1; op_r = long_op; a_r = 32'd1000; b_r = 32'd7;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    clear = 1'b1;
    #1;
    chk("clear_C", C, 64'h0);
    chk("clear_flags", {60'h0, busy, done, div_by_zero, illegal_op}, 64'h0);
    model_reset();
    tick();
    clear = 1'b0;
    for (int i = 0; i < 40; i++) tick();
    chk("clear_no_done", 64'(done_cnt - dc0), 64'd0);
    run_op(5'b00001, 32'd2, 32'd3, lat, bcnt);
    chk("post_clear_add", C, 64'd5);

    // Randomized traffic, including starts while busy and rare clears.
    for (int i = 0; i < 2500; i++) begin
      start = ($urandom_range(0, 1) == 0);
      if ($urandom_range(0, 15) < 13) op_r = ops[$urandom_range(0, 12)];
      else op_r = 5'($urandom);
      a_r = pick();
      b_r = pick();
      clear = ($urandom_range(0, 599) == 0);
      tick();
      clear = 1'b0;
    end
    start = 1'b0;
    for (int i = 0; i < 40; i++) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
